// File: rtl/result_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : result_transmitter
//  Purpose  : Transmit-side framer for the matrix-vector accelerator. Latches a
//             result vector and its length on start, then hands a framed
//             packet to the UART transmitter one byte at a time:
//                 FE, LEN, 05, element[0] .. element[LEN-1], EF
//             LEN is the requested length saturated to WORD_LENGTH.
//  Ports    : clk            - system clock, rising edge
//             reset          - synchronous active-high reset
//             start          - one-cycle send request, honoured only when idle
//             Result_Vector  - WORD_LENGTH elements, element i at [i*W +: W]
//             Result_length  - number of valid elements
//             tx_done        - UART TX finished shifting the current byte
//             Transmit       - one-cycle strobe, DataToTransmit is valid
//             DataToTransmit - byte being sent, stable until tx_done
//             busy           - a frame is in progress
//             done           - one-cycle pulse after the tail byte completes
//  Revision : 1.0 - initial release
// ============================================================================
module result_transmitter #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [WORD_LENGTH*WORD_LENGTH-1:0]   Result_Vector,
    input  logic [WORD_LENGTH-1:0]               Result_length,
    input  logic                                 tx_done,
    output logic                                 Transmit,
    output logic [WORD_LENGTH-1:0]               DataToTransmit,
    output logic                                 busy,
    output logic                                 done
);

    // Byte index spans 0 .. WORD_LENGTH+3
    localparam int C_IDX_W  = $clog2(WORD_LENGTH + 4);
    localparam int C_ELEM_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [WORD_LENGTH-1:0] C_HEADER  = WORD_LENGTH'(8'hFE);
    localparam logic [WORD_LENGTH-1:0] C_CMD     = WORD_LENGTH'(8'h05);
    localparam logic [WORD_LENGTH-1:0] C_TAIL    = WORD_LENGTH'(8'hEF);
    localparam logic [WORD_LENGTH-1:0] C_MAX_LEN = WORD_LENGTH'(WORD_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [C_IDX_W-1:0]      r_idx;
    logic [WORD_LENGTH-1:0]  r_len;
    logic [WORD_LENGTH-1:0]  r_elem [WORD_LENGTH];
    logic                    r_transmit;
    logic [WORD_LENGTH-1:0]  r_data;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_next_state;
    logic [C_IDX_W-1:0]      w_next_idx;
    logic                    w_capture;
    logic [C_IDX_W-1:0]      w_tail_idx;
    logic [C_ELEM_W-1:0]     w_elem_sel;
    logic [WORD_LENGTH-1:0]  w_next_byte;
    logic [WORD_LENGTH-1:0]  w_len_sat;

    assign w_len_sat  = (Result_length > C_MAX_LEN) ? C_MAX_LEN : Result_length;
    assign w_tail_idx = C_IDX_W'(r_len) + C_IDX_W'(3);
    assign w_elem_sel = C_ELEM_W'(w_next_idx - C_IDX_W'(3));

    // Next state and next byte index
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_idx   = '0;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done) begin
                    if (r_idx == w_tail_idx) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_idx   = r_idx + C_IDX_W'(1);
                        w_next_state = S_SEND;
                    end
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Byte selected by the upcoming index. Index 0 is the constant header, so
    // the captured registers are never needed in the same cycle they load.
    always_comb begin
        w_next_byte = r_elem[w_elem_sel];
        if (w_next_idx == C_IDX_W'(0)) begin
            w_next_byte = C_HEADER;
        end else if (w_next_idx == C_IDX_W'(1)) begin
            w_next_byte = r_len;
        end else if (w_next_idx == C_IDX_W'(2)) begin
            w_next_byte = C_CMD;
        end else if (w_next_idx == w_tail_idx) begin
            w_next_byte = C_TAIL;
        end
    end

    // State, captured frame contents and registered outputs. Outputs are
    // derived from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_len      <= '0;
            r_transmit <= 1'b0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < WORD_LENGTH; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_transmit <= (w_next_state == S_SEND);
            r_busy     <= (w_next_state != S_IDLE);
            r_done     <= (w_next_state == S_DONE);
            if (w_next_state == S_SEND) begin
                r_data <= w_next_byte;
            end
            if (w_capture) begin
                r_len <= w_len_sat;
                for (int i = 0; i < WORD_LENGTH; i++) begin
                    r_elem[i] <= Result_Vector[i*WORD_LENGTH +: WORD_LENGTH];
                end
            end
        end
    end

    assign Transmit       = r_transmit;
    assign DataToTransmit = r_data;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_result_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_transmitter
//  Purpose  : Self-checking bench for result_transmitter. A UART TX responder
//             acknowledges each byte after a programmable delay; received
//             frames are compared with a frame built directly from the
//             packet format.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_transmitter;

    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   Result_Vector;
    logic [7:0]    Result_length;
    logic          tx_done;
    logic          Transmit;
    logic [7:0]    DataToTransmit;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    result_transmitter #(.WORD_LENGTH(WL)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .Result_Vector  (Result_Vector),
        .Result_length  (Result_length),
        .tx_done        (tx_done),
        .Transmit       (Transmit),
        .DataToTransmit (DataToTransmit),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        logic [7:0]  len;
        logic [63:0] vec;
        int          delay;
        bit          disturb;
        int          exp_bytes;
        logic [7:0]  exp_len;
    } vec_t;

    vec_t       tbl [5];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: header, saturated length, command, elements, tail
    task automatic build_frame(input logic [7:0] len, input logic [63:0] vec);
        int n;
        n = (len > 8'd8) ? 8 : int'(len);
        exp_q.delete();
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'(n));
        exp_q.push_back(8'h05);
        for (int i = 0; i < n; i++) exp_q.push_back(vec[i*8 +: 8]);
        exp_q.push_back(8'hEF);
    endtask

    task automatic compare_frame(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    // Starts a frame and plays UART TX until the done pulse (or budget runs out).
    task automatic run_frame(input logic [7:0] len, input logic [63:0] vec,
                             input int delay, input bit disturb,
                             output int n_done, output bit proto_ok, output bit timed_out);
        int         cnt;
        bit         waiting;
        bit         disturbed;
        bit         expect_next;
        logic [7:0] held;
        got_q.delete();
        n_done      = 0;
        proto_ok    = 1'b1;
        timed_out   = 1'b1;
        waiting     = 1'b0;
        disturbed   = 1'b0;
        cnt         = 0;
        held        = 8'h00;
        Result_length = len;
        Result_Vector = vec;
        tx_done     = 1'b0;
        start       = 1'b1;
        expect_next = 1'b1;
        for (int b = 0; b < 3000; b++) begin
            step();
            start   = 1'b0;
            tx_done = 1'b0;
            // Next strobe must follow a start or tx_done with no bubble
            if (expect_next && !Transmit && !done) proto_ok = 1'b0;
            expect_next = 1'b0;
            if (done) begin
                n_done++;
                if (!busy) proto_ok = 1'b0;
                step();
                if (busy || Transmit || done) proto_ok = 1'b0;
                timed_out = 1'b0;
                break;
            end
            if (!busy) proto_ok = 1'b0;
            if (Transmit) begin
                if (waiting) proto_ok = 1'b0;
                got_q.push_back(DataToTransmit);
                held    = DataToTransmit;
                waiting = 1'b1;
                cnt     = delay;
            end else if (waiting) begin
                if (DataToTransmit !== held) proto_ok = 1'b0;
                if (disturb && !disturbed && got_q.size() == 2) begin
                    start         = 1'b1;
                    Result_Vector = ~vec;
                    disturbed     = 1'b1;
                end
                if (cnt == 0) begin
                    tx_done     = 1'b1;
                    waiting     = 1'b0;
                    expect_next = 1'b1;
                end else begin
                    cnt--;
                end
            end
        end
        start   = 1'b0;
        tx_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_done;
        bit   proto_ok;
        bit   timed_out;
        int   n_tx;
        int   n_dn;
        bit   aborted;
        logic [7:0] byte4;

        tbl[0] = '{8'd3,  64'h0000_0000_0033_2211, 0,  1'b0, 7,  8'h03};
        tbl[1] = '{8'd0,  64'h0000_0000_0000_0000, 0,  1'b0, 4,  8'h00};
        tbl[2] = '{8'h0C, 64'h0807_0605_0403_0201, 0,  1'b0, 12, 8'h08};
        tbl[3] = '{8'd3,  64'h0000_0000_0033_2211, 3,  1'b1, 7,  8'h03};
        tbl[4] = '{8'd4,  64'h0000_0000_A4A3_A2A1, 50, 1'b0, 8,  8'h04};

        reset = 1'b1; start = 1'b0; tx_done = 1'b0;
        Result_Vector = '0; Result_length = '0;
        repeat (3) step();
        check("reset_transmit", Transmit, 1'b0);
        check("reset_data", DataToTransmit, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;
        step();

        // Spurious tx_done while idle
        n_tx = 0;
        tx_done = 1'b1;
        repeat (4) begin
            step();
            if (Transmit || busy || done) n_tx++;
        end
        tx_done = 1'b0;
        step();
        check("idle_txdone_ignored", n_tx, 0);

        for (int t = 0; t < 5; t++) begin
            build_frame(tbl[t].len, tbl[t].vec);
            run_frame(tbl[t].len, tbl[t].vec, tbl[t].delay, tbl[t].disturb,
                      n_done, proto_ok, timed_out);
            compare_frame($sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_exp_bytes", t), got_q.size(), tbl[t].exp_bytes);
            check($sformatf("tbl%0d_len_byte", t),
                  (got_q.size() > 1) ? {24'h0, got_q[1]} : 32'hFFFF_FFFF, tbl[t].exp_len);
            check($sformatf("tbl%0d_done", t), n_done, 1);
            check($sformatf("tbl%0d_protocol", t), proto_ok, 1'b1);
            check($sformatf("tbl%0d_timeout", t), timed_out, 1'b0);
            n_tx = 0;
            repeat (6) begin
                step();
                if (Transmit || busy || done) n_tx++;
            end
            check($sformatf("tbl%0d_quiet_after", t), n_tx, 0);
        end

        // Reset during data byte index 4, together with its tx_done
        Result_length = 8'd6;
        Result_Vector = 64'h0000_6655_4433_2211;
        start   = 1'b1;
        n_tx    = 0;
        aborted = 1'b0;
        byte4   = 8'h00;
        for (int c = 0; c < 200 && !aborted; c++) begin
            step();
            start   = 1'b0;
            tx_done = 1'b0;
            if (Transmit) begin
                n_tx++;
                if (n_tx == 5) begin
                    byte4 = DataToTransmit;
                    step();
                    reset   = 1'b1;
                    tx_done = 1'b1;
                    aborted = 1'b1;
                end
            end else if (busy) begin
                tx_done = 1'b1;
            end
        end
        check("abort_reached", aborted, 1'b1);
        check("abort_byte4", byte4, 8'h22);
        step();
        reset   = 1'b0;
        tx_done = 1'b0;
        check("abort_transmit", Transmit, 1'b0);
        check("abort_data", DataToTransmit, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        n_dn = 0;
        repeat (8) begin
            step();
            if (done || Transmit) n_dn++;
        end
        check("abort_no_done", n_dn, 0);
        build_frame(8'd2, 64'h0000_0000_0000_BEEF);
        run_frame(8'd2, 64'h0000_0000_0000_BEEF, 1, 1'b0, n_done, proto_ok, timed_out);
        compare_frame("post_abort");
        check("post_abort_done", n_done, 1);
        check("post_abort_protocol", proto_ok, 1'b1);

        // Randomized back-to-back frames
        for (int k = 0; k < 20; k++) begin
            logic [7:0]  rlen;
            logic [63:0] rvec;
            int          rdel;
            rlen = 8'($urandom_range(0, 12));
            rvec = {$urandom, $urandom};
            rdel = int'($urandom_range(0, 3));
            build_frame(rlen, rvec);
            run_frame(rlen, rvec, rdel, 1'b0, n_done, proto_ok, timed_out);
            compare_frame($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_done", k), n_done, 1);
            check($sformatf("rnd%0d_protocol", k), proto_ok, 1'b1);
            check($sformatf("rnd%0d_timeout", k), timed_out, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
